// File: rtl/mem_access_if.sv
// Bundle of handshake and data-memory signals around the memory-access stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic        zero;
  logic [31:0] branch_target;
  logic        is_branch;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic        pc_src;
  logic [31:0] branch_target_out;
  logic        err;

  modport slave (
    input  in_valid, alu_res, store_data, zero, branch_target, is_branch,
           mem_read, mem_write, funct3, dmem_ack, dmem_rdata, out_ready,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           out_valid, wb_data, pc_src, branch_target_out, err
  );

  modport master (
    output in_valid, alu_res, store_data, zero, branch_target, is_branch,
           mem_read, mem_write, funct3, dmem_ack, dmem_rdata, out_ready,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           out_valid, wb_data, pc_src, branch_target_out, err
  );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory-access stage: captures one execute result, performs at most one
// data-memory transfer with a bounded wait, and holds the result until taken.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  mem_access_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          load_q, load_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wb_q, wb_d;
  logic          err_q, err_d;
  logic          pc_src_q, pc_src_d;
  logic [31:0]   bt_q, bt_d;

  function automatic logic op_legal(input logic rd, input logic wr,
                                    input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd && wr) begin
      ok = 1'b0;
    end else if (rd) begin
      case (f3)
        3'b000, 3'b100: ok = 1'b1;
        3'b001, 3'b101: ok = ~off[0];
        3'b010:         ok = (off == 2'b00);
        default:        ok = 1'b0;
      endcase
    end else if (wr) begin
      case (f3)
        3'b000:  ok = 1'b1;
        3'b001:  ok = ~off[0];
        3'b010:  ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Byte enables in [35:32], lane-replicated write data in [31:0].
  function automatic logic [35:0] store_lanes(input logic wr, input logic [2:0] f3,
                                              input logic [1:0] off, input logic [31:0] sd);
    logic [35:0] r;
    r = {4'b1111, 32'h0000_0000};
    if (wr) begin
      case (f3)
        3'b000:  r = {4'b0001 << off, {4{sd[7:0]}}};
        3'b001:  r = {4'b0011 << off, {2{sd[15:0]}}};
        3'b010:  r = {4'b1111, sd};
        default: r = {4'b0000, 32'h0000_0000};
      endcase
    end else begin
      r = {4'b1111, 32'h0000_0000};
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = rd;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Next-state and captured-value logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    f3_d     = f3_q;
    load_d   = load_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wb_d     = wb_q;
    err_d    = err_q;
    pc_src_d = pc_src_q;
    bt_d     = bt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          pc_src_d = bus.is_branch & bus.zero;
          bt_d     = bus.branch_target;
          off_d    = bus.alu_res[1:0];
          f3_d     = bus.funct3;
          load_d   = bus.mem_read;
          if (!bus.mem_read && !bus.mem_write) begin
            wb_d    = bus.alu_res;
            err_d   = 1'b0;
            state_d = S_HOLD;
          end else if (op_legal(bus.mem_read, bus.mem_write, bus.funct3, bus.alu_res[1:0])) begin
            cnt_d          = '0;
            addr_d         = {bus.alu_res[31:2], 2'b00};
            we_d           = bus.mem_write;
            {be_d, wdata_d} = store_lanes(bus.mem_write, bus.funct3, bus.alu_res[1:0],
                                          bus.store_data);
            wb_d           = 32'h0000_0000;
            err_d          = 1'b0;
            state_d        = S_ACCESS;
          end else begin
            wb_d    = 32'h0000_0000;
            err_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        // An ack on the last permitted cycle still completes the transfer.
        if (bus.dmem_ack || (cnt_q == CNT_LAST)) begin
          wb_d    = (bus.dmem_ack && load_q) ? load_extract(bus.dmem_rdata, off_q, f3_q)
                                             : 32'h0000_0000;
          err_d   = ~bus.dmem_ack;
          addr_d  = 32'h0000_0000;
          wdata_d = 32'h0000_0000;
          be_d    = 4'b0000;
          we_d    = 1'b0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      off_q    <= 2'b00;
      f3_q     <= 3'b000;
      load_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      be_q     <= 4'b0000;
      wb_q     <= 32'h0000_0000;
      err_q    <= 1'b0;
      pc_src_q <= 1'b0;
      bt_q     <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      load_q   <= load_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wb_q     <= wb_d;
      err_q    <= err_d;
      pc_src_q <= pc_src_d;
      bt_q     <= bt_d;
    end
  end

  assign bus.in_ready          = (state_q == S_IDLE);
  assign bus.dmem_req          = (state_q == S_ACCESS);
  assign bus.out_valid         = (state_q == S_HOLD);
  assign bus.dmem_we           = we_q;
  assign bus.dmem_addr         = addr_q;
  assign bus.dmem_wdata        = wdata_q;
  assign bus.dmem_be           = be_q;
  assign bus.wb_data           = wb_q;
  assign bus.err               = err_q;
  assign bus.pc_src            = pc_src_q;
  assign bus.branch_target_out = bt_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomised self-checking bench for mem_access against a behavioural model of
// the stage's load/store, alignment, timeout and handshake rules.
module tb_mem_access;
  localparam int TO = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic ready_early;

  mem_access_if bus ();
  mem_access #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations collected by the drivers
  int          o_req, o_lat;
  logic        o_stable, o_ov, o_err, o_pc, o_we0, o_hold_ok, o_idle;
  logic [31:0] o_addr0, o_wd0, o_wb, o_bt;
  logic [3:0]  o_be0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: what the stage should produce for one operation.
  function automatic void model(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                output logic mem, output logic er, output logic [31:0] wb,
                                output logic [3:0] be, output logic [31:0] wd);
    int nb;
    bit legal;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    legal = mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    mem = 1'b0; er = 1'b0; wb = 32'h0; be = 4'h0; wd = 32'h0;
    if (!mr && !mw) begin
      wb = a;
    end else if ((mr && mw) || !legal || ((a % nb) != 0)) begin
      er = 1'b1;
    end else begin
      mem = 1'b1;
      if (mw) begin
        be = 4'(((1 << nb) - 1) << (a % 4));
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % nb) +: 8];
      end else begin
        be = 4'hF;
        v = ({32'h0, rd} >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 64'd1);
        if (!f3[2] && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        wb = v[31:0];
      end
    end
  endfunction

  // Presents one operation, answers the bus, and records what the stage did.
  task automatic drive_op(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic br,
                          input logic z, input logic [31:0] bt, input int ack_after,
                          input logic [31:0] rd);
    int acc;
    acc = 0;
    bus.in_valid = 1'b1; bus.mem_read = mr; bus.mem_write = mw; bus.funct3 = f3;
    bus.alu_res = a; bus.store_data = sd; bus.is_branch = br; bus.zero = z;
    bus.branch_target = bt; bus.out_ready = ready_early;
    tick();
    bus.in_valid = 1'b0; bus.alu_res = $urandom; bus.store_data = $urandom;
    bus.branch_target = $urandom; bus.funct3 = 3'($urandom); bus.zero = ~z;
    o_req = 0; o_lat = 1; o_stable = 1'b1;
    o_addr0 = bus.dmem_addr; o_be0 = bus.dmem_be; o_wd0 = bus.dmem_wdata; o_we0 = bus.dmem_we;
    for (int c = 0; c < 40 && !bus.out_valid; c++) begin
      if (bus.dmem_req) begin
        o_req++;
        if (bus.dmem_addr !== o_addr0 || bus.dmem_be !== o_be0 ||
            bus.dmem_wdata !== o_wd0 || bus.dmem_we !== o_we0) o_stable = 1'b0;
        bus.dmem_ack = (ack_after == acc);
        acc++;
      end else begin
        bus.dmem_ack = 1'b0;
      end
      bus.dmem_rdata = bus.dmem_ack ? rd : $urandom;
      tick();
      o_lat++;
    end
    bus.dmem_ack = 1'b0;
    o_ov = bus.out_valid; o_wb = bus.wb_data; o_err = bus.err;
    o_pc = bus.pc_src; o_bt = bus.branch_target_out;
  endtask

  // Stalls downstream for n cycles (with stray acks) and then accepts the result.
  task automatic hold_and_release(input int n);
    o_hold_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.dmem_ack = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      tick();
      if (!bus.out_valid || bus.wb_data !== o_wb || bus.err !== o_err ||
          bus.pc_src !== o_pc || bus.branch_target_out !== o_bt || bus.dmem_req) o_hold_ok = 1'b0;
    end
    bus.dmem_ack = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    o_idle = bus.in_ready && !bus.out_valid && !bus.dmem_req;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.pc_src !== 1'b0 || bus.err !== 1'b0)
      begin errors++; $display("FAIL reset_flags got ov=%b req=%b we=%b pc=%b err=%b want all 0", bus.out_valid, bus.dmem_req, bus.dmem_we, bus.pc_src, bus.err); end
    checks++; if (bus.wb_data !== 32'h0 || bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0 || bus.branch_target_out !== 32'h0 || bus.dmem_be !== 4'h0)
      begin errors++; $display("FAIL reset_data got wb=%h addr=%h wd=%h bt=%h be=%b want 0", bus.wb_data, bus.dmem_addr, bus.dmem_wdata, bus.branch_target_out, bus.dmem_be); end
  endtask

  task automatic test_directed();
    // LB 0x1003 with immediate ack
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h80FF_0000);
    checks++; if (o_addr0 !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr got %h want 00001000", o_addr0); end
    checks++; if (o_wb !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb got %h want ffffff80", o_wb); end
    checks++; if (o_lat !== 2 || o_ov !== 1'b1) begin errors++; $display("FAIL lb_latency got %0d/%b want 2/1", o_lat, o_ov); end
    hold_and_release(0);
    // SH 0x2002
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0, 0, 32'h0);
    checks++; if (o_be0 !== 4'b1100 || o_wd0 !== 32'hBEEF_BEEF || o_we0 !== 1'b1)
      begin errors++; $display("FAIL sh_lanes got be=%b wd=%h we=%b want 1100 beefbeef 1", o_be0, o_wd0, o_we0); end
    checks++; if (o_err !== 1'b0 || o_wb !== 32'h0) begin errors++; $display("FAIL sh_result got err=%b wb=%h want 0 0", o_err, o_wb); end
    hold_and_release(0);
    // LW 0x0006 is misaligned
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h1234_5678);
    checks++; if (o_req !== 0 || o_lat !== 1) begin errors++; $display("FAIL lw_misaligned_req got req=%0d lat=%0d want 0 1", o_req, o_lat); end
    checks++; if (o_err !== 1'b1 || o_wb !== 32'h0) begin errors++; $display("FAIL lw_misaligned_err got err=%b wb=%h want 1 0", o_err, o_wb); end
    hold_and_release(0);
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 32'h0, -1, 32'h0);
    checks++; if (o_req !== TO) begin errors++; $display("FAIL timeout_req_cycles got %0d want %0d", o_req, TO); end
    checks++; if (o_ov !== 1'b1 || o_err !== 1'b1 || o_wb !== 32'h0) begin errors++; $display("FAIL timeout_err got ov=%b err=%b wb=%h want 1 1 0", o_ov, o_err, o_wb); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL timeout_bus_stable got %b want 1", o_stable); end
    hold_and_release(1);
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL timeout_idle got %b want 1", o_idle); end
  endtask

  task automatic test_branch_hold();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0AA0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 0, 32'h0);
    checks++; if (o_pc !== 1'b1 || o_bt !== 32'h0000_0040 || o_wb !== 32'h0000_0AA0 || o_lat !== 1)
      begin errors++; $display("FAIL branch_out got pc=%b bt=%h wb=%h lat=%0d want 1 40 aa0 1", o_pc, o_bt, o_wb, o_lat); end
    hold_and_release(3);
    checks++; if (o_hold_ok !== 1'b1) begin errors++; $display("FAIL branch_hold_stable got %b want 1", o_hold_ok); end
    checks++; if (o_idle !== 1'b1) begin errors++; $display("FAIL branch_idle got %b want 1", o_idle); end
  endtask

  task automatic test_random();
    logic mr, mw, br, z, e_mem, e_err;
    logic [2:0] f3;
    logic [31:0] a, sd, rd, bt, e_wb, e_wd;
    logic [3:0] e_be;
    int kind, ack_after, e_req, e_lat;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 2 && kind <= 5) || kind == 9;
      mw = (kind >= 6);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; sd = $urandom; rd = $urandom; bt = $urandom;
      br = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
      ack_after = ($urandom_range(0, 6) == 0) ? -1 : $urandom_range(0, TO - 1);
      model(mr, mw, f3, a, sd, rd, e_mem, e_err, e_wb, e_be, e_wd);
      if (e_mem && ack_after < 0) begin e_err = 1'b1; e_wb = 32'h0; e_req = TO; e_lat = TO + 1; end
      else if (e_mem) begin e_req = ack_after + 1; e_lat = ack_after + 2; end
      else begin e_req = 0; e_lat = 1; end
      drive_op(mr, mw, f3, a, sd, br, z, bt, ack_after, rd);
      checks++; if (o_req !== e_req || o_lat !== e_lat || o_ov !== 1'b1)
        begin errors++; $display("FAIL rand%0d_timing got req=%0d lat=%0d ov=%b want %0d %0d 1", n, o_req, o_lat, o_ov, e_req, e_lat); end
      checks++; if (o_wb !== e_wb || o_err !== e_err)
        begin errors++; $display("FAIL rand%0d_result got wb=%h err=%b want %h %b", n, o_wb, o_err, e_wb, e_err); end
      checks++; if (o_pc !== (br & z) || o_bt !== bt)
        begin errors++; $display("FAIL rand%0d_branch got pc=%b bt=%h want %b %h", n, o_pc, o_bt, br & z, bt); end
      if (e_mem) begin
        checks++; if (o_addr0 !== {a[31:2], 2'b00} || o_be0 !== e_be || o_wd0 !== e_wd || o_we0 !== mw || o_stable !== 1'b1)
          begin errors++; $display("FAIL rand%0d_bus got addr=%h be=%b wd=%h we=%b st=%b want %h %b %h %b 1", n, o_addr0, o_be0, o_wd0, o_we0, o_stable, {a[31:2], 2'b00}, e_be, e_wd, mw); end
      end
      hold_and_release($urandom_range(0, 2));
      checks++; if (o_hold_ok !== 1'b1 || o_idle !== 1'b1)
        begin errors++; $display("FAIL rand%0d_release got hold=%b idle=%b want 1 1", n, o_hold_ok, o_idle); end
      // Stray ack while idle must not start anything
      bus.dmem_ack = 1'b1; tick(); bus.dmem_ack = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dmem_req !== 1'b0)
        begin errors++; $display("FAIL rand%0d_idle_ack got rdy=%b ov=%b req=%b want 1 0 0", n, bus.in_ready, bus.out_valid, bus.dmem_req); end
    end
  endtask

  task automatic test_back_to_back();
    ready_early = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) drive_op(1'b0, 1'b0, 3'b000, 32'h100 + 32'(n), 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0);
      else drive_op(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'hA5C3_7E11);
      checks++; if (o_ov !== 1'b1 || o_lat !== ((n % 2 == 0) ? 1 : 2))
        begin errors++; $display("FAIL b2b%0d_visible got ov=%b lat=%0d want 1 %0d", n, o_ov, o_lat, (n % 2 == 0) ? 1 : 2); end
      checks++; if (o_wb !== ((n % 2 == 0) ? 32'h100 + 32'(n) : 32'h0000_007E))
        begin errors++; $display("FAIL b2b%0d_wb got %h", n, o_wb); end
      tick();
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        begin errors++; $display("FAIL b2b%0d_accept got rdy=%b ov=%b want 1 0", n, bus.in_ready, bus.out_valid); end
    end
    ready_early = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_access();
    bus.in_valid = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.funct3 = 3'b010;
    bus.alu_res = 32'h0000_0300; bus.is_branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h0000_0ABC;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rstacc_req got %b want 1", bus.dmem_req); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rstacc_drop got %b want 0", bus.dmem_req); end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.dmem_ack = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.pc_src !== 1'b0 || bus.err !== 1'b0)
      begin errors++; $display("FAIL rstacc_flags got rdy=%b ov=%b req=%b we=%b pc=%b err=%b want 1 0 0 0 0 0", bus.in_ready, bus.out_valid, bus.dmem_req, bus.dmem_we, bus.pc_src, bus.err); end
    checks++; if (bus.wb_data !== 32'h0 || bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0 || bus.branch_target_out !== 32'h0 || bus.dmem_be !== 4'h0)
      begin errors++; $display("FAIL rstacc_data got wb=%h addr=%h wd=%h bt=%h be=%b want 0", bus.wb_data, bus.dmem_addr, bus.dmem_wdata, bus.branch_target_out, bus.dmem_be); end
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstacc_no_valid got %b want 0", bus.out_valid); end
  endtask

  initial begin
    errors = 0; checks = 0; ready_early = 1'b0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.alu_res = 32'h0; bus.store_data = 32'h0; bus.zero = 1'b0;
    bus.branch_target = 32'h0; bus.is_branch = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.funct3 = 3'b000; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_timeout();
    test_branch_hold();
    test_random();
    test_back_to_back();
    test_reset_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum ACCESS-state cycles to wait for dmem_ack before flagging a bus error.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-low reset (reset when rst==0 at a rising clk edge).
REQ-004 in_valid  input  1; in_ready  output  1  SHALL form the upstream handshake from the execution stage.
REQ-005 alu_res  input  32 (effective address / ALU result); store_data  input  32 (second register value); zero  input  1; branch_target  input  32; is_branch  input  1.
REQ-006 mem_read  input  1; mem_write  input  1; funct3  input  3 (access size/sign).
REQ-007 dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32 (word-aligned); dmem_wdata  output  32; dmem_be  output  4; dmem_ack  input  1; dmem_rdata  input  32.
REQ-008 out_valid  output  1; out_ready  input  1; wb_data  output  32; pc_src  output  1; branch_target_out  output  32; err  output  1.

Function
REQ-009 FSM states SHALL be IDLE, ACCESS, HOLD; in_ready=1 only in IDLE; dmem_req=1 only in ACCESS; out_valid=1 only in HOLD.
REQ-010 IDLE with in_valid=1: SHALL capture all inputs at the edge; next state ACCESS if a legal memory op, else HOLD.
REQ-011 Non-memory op (mem_read=0, mem_write=0): wb_data=alu_res, reaches HOLD one cycle after capture.
REQ-012 Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-013 Illegal funct3, mem_read&mem_write both 1, halfword addr[0]=1, or word addr[1:0]!=0 SHALL go directly to HOLD with err=1, no bus request issued, wb_data=0.
REQ-014 In ACCESS: dmem_addr={addr[31:2],2'b00}, dmem_we=mem_write, dmem_be/dmem_wdata SHALL be held stable until ack or timeout.
REQ-015 Store lanes: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=4'b0011<<addr[1:0], wdata=halfword replicated x2; SW be=4'b1111; loads drive be=4'b1111, wdata=0.
REQ-016 dmem_ack=1 in ACCESS: SHALL capture dmem_rdata, move to HOLD next cycle; load result = lane selected by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU); store wb_data=0.
REQ-017 Wait counter SHALL clear on ACCESS entry and count each ACCESS cycle without ack; after TIMEOUT such cycles SHALL go to HOLD with err=1, wb_data=0.
REQ-018 dmem_ack in IDLE or HOLD SHALL be ignored.
REQ-019 pc_src SHALL equal captured is_branch & zero; branch_target_out = captured branch_target; both valid while out_valid=1.
REQ-020 HOLD: outputs SHALL stay stable until out_ready=1; then next state IDLE; out_ready=1 on the same edge that HOLD is entered has no effect until out_valid is visible.
REQ-021 Minimum latency: capture edge to out_valid = 1 cycle (non-memory), 2 cycles (memory with immediate ack).

Reset
REQ-022 rst=0 at an edge SHALL force IDLE, counter=0, and out_valid, dmem_req, dmem_we, pc_src, err=0; wb_data, dmem_addr, dmem_wdata, branch_target_out=0; dmem_be=4'b0000.
REQ-023 Reset during ACCESS SHALL drop dmem_req the following cycle and discard any later ack.

Verification
REQ-024 LB at 0x1003, dmem_rdata=0x80FF_0000, ack next cycle -> dmem_addr=0x1000, wb_data=0xFFFF_FF80, out_valid 2 cycles after capture.
REQ-025 SH at 0x2002, store_data=0x0000_BEEF -> dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, err=0.
REQ-026 LW at 0x0006 -> no dmem_req ever, HOLD next cycle, err=1, wb_data=0.
REQ-027 LW with TIMEOUT=4 and ack never asserted -> dmem_req high exactly 4 cycles, then err=1 in HOLD.
REQ-028 Branch, zero=1, branch_target=0x40, out_ready held 0 for 3 cycles -> pc_src=1, branch_target_out=0x40 stable all 3 cycles; IDLE after out_ready=1.
REQ-029 rst=0 while dmem_req=1, ack arrives next cycle -> all outputs reset values, in_ready=1, no out_valid.
